// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking meter datapath. The coin stage and the
// countdown stage both import this package so that they agree on the width of
// a time value and on its upper limit.
//
// Contents:
//   TIME_W        width of every time value (units of purchased time)
//   MAX_TIME_DEF  default saturation limit for purchased time
//   meter_state_t countdown controller states
// -----------------------------------------------------------------------------
package parking_pkg;

    localparam int TIME_W       = 8;
    localparam int MAX_TIME_DEF = 99;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } meter_state_t;

endpackage : parking_pkg

// File: rtl/parking_countdown_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running modulo-DIV counter that produces a single-cycle tick on the
// cycle its count sits at DIV-1. Used both as the one-second prescaler and as
// the expiry LED blink divider.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   clear  in   synchronous clear; forces the count to 0 and masks the tick
//   en     in   count enable
//   tick   out  high for one cycle every DIV enabled cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // A clear in the same cycle wins over the tick so that the owner can
    // abandon a period without acting on it.
    assign tick = en & ~clear & (cnt_q == LAST);

    // NOTE: state is updated with non-blocking assignments only; blocking
    // assignments here would make the result depend on process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_gen

// File: rtl/parking_countdown.sv
// -----------------------------------------------------------------------------
// parking_countdown
// Countdown stage of the parking meter. While idle the display follows the
// purchased time; a rising edge on the start switch latches it and counts it
// down once per TICK_DIV cycles. Reaching zero enters EXPIRED, where the LED
// blinks until the switch is released.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   time_in    in   purchased time from the coin stage (clamped to MAX_TIME)
//   sw_start   in   start switch level, synchronous to clk
//   time_left  out  remaining time, 0..MAX_TIME
//   bcd_tens   out  tens digit of time_left
//   bcd_ones   out  ones digit of time_left
//   running    out  high while counting down
//   expired    out  high once the time has run out
//   led_blink  out  expiry blink, low outside EXPIRED
// -----------------------------------------------------------------------------
module parking_countdown
    import parking_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int MAX_TIME  = MAX_TIME_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TIME_W-1:0] time_in,
    input  logic              sw_start,
    output logic [TIME_W-1:0] time_left,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic              running,
    output logic              expired,
    output logic              led_blink
);

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] ONE_T = TIME_W'(1);

    meter_state_t      state_q,     state_d;
    logic [TIME_W-1:0] time_left_q, time_left_d;
    logic              led_blink_q, led_blink_d;
    logic              sw_start_q;

    logic [TIME_W-1:0] tin;
    logic              start_rise;
    logic              sec_tick;
    logic              blink_tick;
    logic              in_run;
    logic              in_expired;

    assign tin        = (time_in > MAX_T) ? MAX_T : time_in;
    assign start_rise = sw_start & ~sw_start_q;
    assign in_run     = (state_q == RUN);
    assign in_expired = (state_q == EXPIRED);

    // The prescaler is held at 0 outside RUN, so the first decrement lands
    // exactly TICK_DIV cycles after entry. Releasing the switch clears it
    // and masks a coincident tick.
    tick_gen #(.DIV(TICK_DIV)) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .clear (~in_run | ~sw_start),
        .en    (in_run),
        .tick  (sec_tick)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk   (clk),
        .reset (reset),
        .clear (~in_expired | ~sw_start),
        .en    (in_expired),
        .tick  (blink_tick)
    );

    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        led_blink_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Display follows coins as they are inserted; the same value
                // is the one latched on start.
                time_left_d = tin;
                if (start_rise && (tin != '0)) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!sw_start) begin
                    state_d = IDLE;
                end else if (sec_tick) begin
                    if (time_left_q <= ONE_T) begin
                        time_left_d = '0;
                        state_d     = EXPIRED;
                    end else begin
                        time_left_d = time_left_q - ONE_T;
                    end
                end
            end

            EXPIRED: begin
                time_left_d = '0;
                if (!sw_start) begin
                    state_d = IDLE;
                end else begin
                    led_blink_d = led_blink_q ^ blink_tick;
                end
            end

            // The unused encoding falls back to a clean idle.
            default: begin
                state_d     = IDLE;
                time_left_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            time_left_q <= '0;
            led_blink_q <= 1'b0;
            sw_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            led_blink_q <= led_blink_d;
            sw_start_q  <= sw_start;
        end
    end

    assign time_left = time_left_q;
    assign bcd_tens  = 4'(time_left_q / TIME_W'(10));
    assign bcd_ones  = 4'(time_left_q % TIME_W'(10));
    assign running   = in_run;
    assign expired   = in_expired;
    assign led_blink = led_blink_q;

endmodule : parking_countdown

// File: tb/tb_parking_countdown.sv
// -----------------------------------------------------------------------------
// tb_parking_countdown
// Directed bench for parking_countdown with TICK_DIV=4, BLINK_DIV=2.
// Inputs change and outputs are sampled 1 ns after a rising clock edge.
// -----------------------------------------------------------------------------
module tb_parking_countdown;

    logic       clk;
    logic       reset;
    logic [7:0] time_in;
    logic       sw_start;
    logic [7:0] time_left;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       expired;
    logic       led_blink;

    int n_checks = 0;
    int n_errors = 0;

    parking_countdown #(
        .TICK_DIV  (4),
        .BLINK_DIV (2),
        .MAX_TIME  (99)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .time_in   (time_in),
        .sw_start  (sw_start),
        .time_left (time_left),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .running   (running),
        .expired   (expired),
        .led_blink (led_blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Checks every output at once against the expected values.
    task automatic check_all(input string tag, input logic [7:0] tl, input logic [3:0] t,
                             input logic [3:0] o, input logic r, input logic e,
                             input logic l);
        check({tag, ".time_left"}, 32'(time_left), 32'(tl));
        check({tag, ".bcd_tens"},  32'(bcd_tens),  32'(t));
        check({tag, ".bcd_ones"},  32'(bcd_ones),  32'(o));
        check({tag, ".running"},   32'(running),   32'(r));
        check({tag, ".expired"},   32'(expired),   32'(e));
        check({tag, ".led_blink"}, 32'(led_blink), 32'(l));
    endtask

    initial begin
        // 1. Reset with live inputs: everything held at zero.
        reset    = 1'b0;
        time_in  = 8'd35;
        sw_start = 1'b1;
        step(3);
        check_all("rst", 8'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        sw_start = 1'b0;
        reset    = 1'b1;
        step(1);
        check_all("idle35", 8'd35, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0);

        // 2. Full countdown from 3 into EXPIRED and the blink pattern.
        time_in = 8'd3;
        step(1);
        check("idle3", 32'(time_left), 32'd3);
        sw_start = 1'b1;
        step(1);                                    // RUN entry edge
        check_all("run3", 8'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        step(3);
        check("pre_tick1", 32'(time_left), 32'd3);
        step(1);
        check("tick1", 32'(time_left), 32'd2);
        step(4);
        check("tick2", 32'(time_left), 32'd1);
        step(3);
        check("pre_tick3.running", 32'(running), 32'd1);
        step(1);
        check_all("exp", 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1);
        check("blink_a", 32'(led_blink), 32'd0);
        step(1);
        check("blink_b", 32'(led_blink), 32'd1);
        step(1);
        check("blink_c", 32'(led_blink), 32'd1);
        step(1);
        check("blink_d", 32'(led_blink), 32'd0);
        step(2);
        check("blink_e", 32'(led_blink), 32'd1);
        check("exp_hold", 32'(time_left), 32'd0);
        sw_start = 1'b0;
        step(1);
        check_all("exp_exit", 8'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 3. Oversized purchase saturates at 99.
        time_in = 8'd120;
        step(1);
        check("clamp_idle", 32'(time_left), 32'd99);
        sw_start = 1'b1;
        step(1);
        check_all("run99", 8'd99, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
        step(4);
        check_all("run98", 8'd98, 4'd9, 4'd8, 1'b1, 1'b0, 1'b0);
        sw_start = 1'b0;
        step(1);
        check("abort99.running", 32'(running), 32'd0);

        // 4. Start with nothing purchased, then no restart without a new edge.
        time_in = 8'd0;
        step(1);
        sw_start = 1'b1;
        step(2);
        check_all("zero_start", 8'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        time_in = 8'd5;
        step(3);
        check("held_sw.running", 32'(running), 32'd0);
        check("held_sw.time_left", 32'(time_left), 32'd5);
        sw_start = 1'b0;
        step(1);
        sw_start = 1'b1;
        step(1);
        check("restart.running", 32'(running), 32'd1);
        check("restart.time_left", 32'(time_left), 32'd5);
        sw_start = 1'b0;
        step(1);

        // 5. Abort on the tick cycle: no decrement, then track time_in again.
        time_in = 8'd7;
        step(1);
        sw_start = 1'b1;
        step(1);                                    // RUN entry at 7
        time_in = 8'd50;
        step(3);                                    // now on the tick cycle
        check("run_ignores_tin", 32'(time_left), 32'd7);
        sw_start = 1'b0;
        step(1);
        check_all("abort7", 8'd7, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0);
        step(1);
        check_all("track50", 8'd50, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);

        // 6a. Asynchronous reset in the middle of RUN.
        time_in = 8'd9;
        step(1);
        sw_start = 1'b1;
        step(3);
        check("mid_run.running", 32'(running), 32'd1);
        reset = 1'b0;
        #1;
        check_all("areset_run", 8'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        sw_start = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);

        // 6b. Asynchronous reset in EXPIRED with the LED lit.
        time_in = 8'd1;
        step(1);
        sw_start = 1'b1;
        step(5);                                    // entry + 4 cycles -> EXPIRED
        check("mid_exp.expired", 32'(expired), 32'd1);
        step(2);
        check("mid_exp.led", 32'(led_blink), 32'd1);
        reset = 1'b0;
        #1;
        check_all("areset_exp", 8'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        sw_start = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        check("post_reset.time_left", 32'(time_left), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_parking_countdown
